// File: rtl/fir_coeff_ctrl_if.sv
// Handshake and FIR-facing signal bundle for the coefficient-load controller.
// The master side is the sample/config source; the slave side is fir_coeff_ctrl.
interface fir_coeff_ctrl_if #(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50
);
    logic                                     cfg_valid;
    logic                                     cfg_ready;
    logic signed [TAP_COEFF_WIDTH-1:0]        cfg_data;
    logic                                     cfg_last;
    logic                                     in_valid;
    logic                                     in_ready;
    logic signed [DATA_WIDTH-1:0]             in_data;
    logic signed [DATA_WIDTH-1:0]             filt_in;
    logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0] tap_coeffs;
    logic                                     out_valid;
    logic                                     busy;

    modport master (
        output cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        input  cfg_ready, in_ready, filt_in, tap_coeffs, out_valid, busy
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_last, in_valid, in_data,
        output cfg_ready, in_ready, filt_in, tap_coeffs, out_valid, busy
    );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// Loads FIR coefficients into a shadow bank while the filter runs, then drains
// the pipeline with zeros and swaps the shadow bank into the active taps.
module fir_coeff_ctrl #(
    parameter int DATA_WIDTH      = 5,
    parameter int TAP_COEFF_WIDTH = 5,
    parameter int NUM_TAPS        = 50
) (
    input logic             clk,
    input logic             rst_n,
    fir_coeff_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_TAPS);
    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(NUM_TAPS);

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_t;

    state_t                                   state;
    logic [IDX_W-1:0]                         idx;
    logic [CNT_W-1:0]                         drain_cnt;
    logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0] shadow;
    logic [NUM_TAPS-1:0][TAP_COEFF_WIDTH-1:0] active;
    logic [1:0]                               vld_sr;
    logic                                     in_ready;
    logic                                     cfg_ready;
    logic                                     busy;
    logic                                     cfg_fire;
    logic                                     in_fire;
    logic                                     commit;

    assign cfg_fire = bus.cfg_valid & cfg_ready;
    assign in_fire  = bus.in_valid & in_ready;
    assign commit   = cfg_fire & (bus.cfg_last | (idx == LAST_IDX));

    assign bus.cfg_ready  = cfg_ready;
    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.tap_coeffs = active;
    assign bus.out_valid  = vld_sr[1];
    assign bus.filt_in    = in_fire ? bus.in_data : {DATA_WIDTH{1'b0}};

    // Ready/busy flags are registered alongside the state so they change on the
    // same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            idx       <= '0;
            drain_cnt <= '0;
            shadow    <= '0;
            active    <= '0;
            vld_sr    <= '0;
            in_ready  <= 1'b1;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            vld_sr <= {vld_sr[0], in_fire};
            case (state)
                RUN: begin
                    if (cfg_fire) begin
                        shadow[idx] <= bus.cfg_data;
                        if (commit) begin
                            // Short frames leave the unloaded upper taps zeroed.
                            for (int j = 0; j < NUM_TAPS; j++) begin
                                if (j > int'(idx)) begin
                                    shadow[j] <= '0;
                                end
                            end
                            idx       <= '0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_END) begin
                        drain_cnt <= '0;
                        state     <= SWAP;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                SWAP: begin
                    active    <= shadow;
                    state     <= RUN;
                    in_ready  <= 1'b1;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= RUN;
                    in_ready  <= 1'b1;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Randomized bench for fir_coeff_ctrl with a cycle-indexed behavioural model
// and a few literal expectations for the documented scenarios.
module tb_fir_coeff_ctrl;
    localparam int DW = 5;
    localparam int CW = 5;
    localparam int N  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_coeff_ctrl_if #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(N)) bus ();

    fir_coeff_ctrl #(.DATA_WIDTH(DW), .TAP_COEFF_WIDTH(CW), .NUM_TAPS(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // The model counts cycles since reset and remembers the commit edge;
    // busy and the coefficient swap are pure functions of that distance.
    int          cyc;
    int          commit_t;
    int          m_idx;
    logic [CW-1:0] m_shadow [N];
    logic [CW-1:0] m_active [N];
    bit          acc_q [$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit m_busy();
        return (cyc >= commit_t + 1) && (cyc <= commit_t + N + 2);
    endfunction

    function automatic logic [N*CW-1:0] pack_active();
        logic [N*CW-1:0] v;
        for (int j = 0; j < N; j++) v[j*CW +: CW] = m_active[j];
        return v;
    endfunction

    task automatic model_reset();
        cyc      = 0;
        commit_t = -100;
        m_idx    = 0;
        for (int j = 0; j < N; j++) begin
            m_shadow[j] = '0;
            m_active[j] = '0;
        end
        acc_q = {1'b0, 1'b0};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                bit acc;
                acc = bus.in_valid && !m_busy();
                if (bus.cfg_valid && !m_busy()) begin
                    m_shadow[m_idx] = bus.cfg_data;
                    if (bus.cfg_last || m_idx == N - 1) begin
                        for (int j = m_idx + 1; j < N; j++) m_shadow[j] = '0;
                        commit_t = cyc;
                        m_idx    = 0;
                    end else begin
                        m_idx++;
                    end
                end
                if (cyc == commit_t + N + 2) begin
                    for (int j = 0; j < N; j++) m_active[j] = m_shadow[j];
                end
                acc_q.push_back(acc);
                void'(acc_q.pop_front());
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("busy",       64'(bus.busy),       64'(m_busy()));
            checkOutput("in_ready",   64'(bus.in_ready),   64'(!m_busy()));
            checkOutput("cfg_ready",  64'(bus.cfg_ready),  64'(!m_busy()));
            checkOutput("out_valid",  64'(bus.out_valid),  64'(acc_q[0]));
            checkOutput("filt_in",    64'(bus.filt_in),
                        (bus.in_valid && !m_busy()) ? 64'(bus.in_data) : 64'd0);
            checkOutput("tap_coeffs", 64'(bus.tap_coeffs), 64'(pack_active()));
        end
    end

    task automatic applyStimulus(input logic cv, input logic [CW-1:0] cd, input logic cl,
                                 input logic iv, input logic [DW-1:0] id);
        @(posedge clk);
        #1;
        bus.cfg_valid = cv;
        bus.cfg_data  = cd;
        bus.cfg_last  = cl;
        bus.in_valid  = iv;
        bus.in_data   = id;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic load_full_1234();
        applyStimulus(1'b1, 5'd1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 5'd2, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 5'd4, 1'b0, 1'b0, '0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int busy_cycles;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;
        bus.cfg_last  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_in_ready",  64'(bus.in_ready),   64'd1);
        checkOutput("reset_cfg_ready", 64'(bus.cfg_ready),  64'd1);
        checkOutput("reset_busy",      64'(bus.busy),       64'd0);
        checkOutput("reset_taps",      64'(bus.tap_coeffs), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] full frame {1,2,3,4}");
        load_full_1234();
        busy_cycles = 0;
        repeat (10) begin
            idle(1);
            @(negedge clk);
            if (bus.busy) busy_cycles++;
        end
        checkOutput("busy_window_len", 64'(busy_cycles), 64'd6);
        checkOutput("taps_full_frame", 64'(bus.tap_coeffs), 64'h20C41);

        $display("[TB] short frame {5,-3}");
        applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 5'h1D, 1'b1, 1'b0, '0);
        idle(10);
        @(negedge clk);
        checkOutput("taps_short_frame", 64'(bus.tap_coeffs), 64'h003A5);
        applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, '0);
        idle(10);
        @(negedge clk);
        checkOutput("taps_reload_idx0", 64'(bus.tap_coeffs), 64'h00007);

        $display("[TB] impulse stream with mid-stream reload");
        load_full_1234();
        idle(10);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 5'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 5'd0);
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b1, 5'd0);
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b1, 5'd3);
        idle(4);

        $display("[TB] commit and sample in the same cycle");
        applyStimulus(1'b1, 5'd9, 1'b1, 1'b1, 5'd3);
        idle(1);
        @(negedge clk);
        checkOutput("same_cycle_busy",     64'(bus.busy),     64'd1);
        checkOutput("same_cycle_in_ready", 64'(bus.in_ready), 64'd0);
        idle(1);
        @(negedge clk);
        checkOutput("same_cycle_out_valid", 64'(bus.out_valid), 64'd1);
        idle(8);

        $display("[TB] reset during drain");
        load_full_1234();
        idle(10);
        applyStimulus(1'b1, 5'd6, 1'b1, 1'b0, '0);
        idle(3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_drain_rst_taps",  64'(bus.tap_coeffs), 64'd0);
        checkOutput("mid_drain_rst_busy",  64'(bus.busy),       64'd0);
        checkOutput("mid_drain_rst_ready", 64'(bus.in_ready),   64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);
        @(negedge clk);
        checkOutput("no_swap_after_rst", 64'(bus.tap_coeffs), 64'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) < 35), CW'($urandom), ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 60), DW'($urandom));
        end
        idle(12);
        @(negedge clk);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
